uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that drains the 8-bit byte FIFO and shifts each byte out on a single asynchronous-serial line: one start bit, 8 data bits LSB first, and one stop bit. It sits directly downstream of the FIFO. It reads bytes through the FIFO's `empty` / `dout` / `pop` handshake, and it is the only consumer of the FIFO. Bit timing comes from an internal baud counter clocked by the system clock.

## Interface
- `CLKS_PER_BIT`, default 16: system-clock cycles per serial bit. Legal range is ≥ 2.
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `fifo_empty`, input, 1: FIFO `empty`.
- `fifo_dout`, input, 8: FIFO `dout`. Valid combinationally whenever `fifo_empty` = 0.
- `pop`, output, 1: FIFO `pop`. Single-cycle strobe; the byte is consumed on that edge.
- `txd`, output, 1: serial line. Idles high.
- `busy`, output, 1: high while a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only with the configuration macro), STOP.
- IDLE:
  - `txd` = 1.
  - If `fifo_empty` = 0: assert `pop`, latch `fifo_dout` into the shift register, reset the baud counter, and go to START.
- START: `txd` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - `txd` = shift_reg[bit index] for `CLKS_PER_BIT` cycles per bit.
  - The index counts 0..7 (3-bit counter).
  - After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP: `txd` = 1 for `CLKS_PER_BIT` cycles.
  - On the last STOP cycle, if `fifo_empty` = 0: assert `pop`, latch the byte, and go directly to START. Frames then run back-to-back with no idle gap.
  - Otherwise go to IDLE.
- `pop` is combinational: `!rst & !fifo_empty & (state == IDLE | last STOP cycle)`. It is never asserted while `fifo_empty` = 1 and never for more than one cycle per byte.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on the last cycle of each bit.
  - The state or bit index advances only on that wrap.
- The shift register is not modified mid-frame. Changes on `fifo_dout` after the pop edge have no effect.

## Timing
- Reset values: `txd` = 1, `busy` = 0, `pop` = 0, state = IDLE, counters = 0.
- Pop-to-start latency:
  - `pop` is high in cycle n.
  - `txd` = 0 and `busy` = 1 from cycle n+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Back-to-back frames:
  - The next start bit begins the cycle after the last STOP cycle.
  - The serial stream is continuous.
  - `busy` stays high across the boundary.
- Bytes arriving in the FIFO mid-frame wait and are popped only at the IDLE or last-STOP check.
- Reset mid-frame:
  - Next edge returns to IDLE with `txd` = 1.
  - The in-flight byte is discarded; it was already popped and is not re-read.
  - `pop` is forced to 0 while `rst` = 1, even if `fifo_empty` = 0.
- FIFO empty exactly on the last STOP cycle: go to IDLE. `busy` drops the following cycle.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: insert a PARITY state between DATA and STOP. It drives `txd` = even parity (XOR of the 8 latched bits) for `CLKS_PER_BIT` cycles. Frame = 11 bits.
  - Undefined: no PARITY state. DATA goes straight to STOP. Frame = 10 bits.

## Test plan
- Reset, idle line: assert `rst` 3 cycles with `fifo_empty` = 0. Required: `pop` = 0, `txd` = 1, `busy` = 0 throughout. After release, `pop` pulses on the first cycle.
- Single byte, `CLKS_PER_BIT` = 4:
  - Stimulus: FIFO holds 0xA5.
  - Required: one `pop` pulse, then `txd` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1 (40 cycles).
  - Then IDLE, and `busy` falls on cycle 41 after the pop.
- Back-to-back: FIFO holds 0x00 and 0xFF.
  - Required: second `pop` on the last STOP cycle of frame 1.
  - Frame 2 start bit begins the next cycle.
  - 80 contiguous cycles with no `txd` = 1 gap beyond the stop bit.
- Parity (macro defined), `CLKS_PER_BIT` = 4:
  - 0xA5 gives parity bit 0 (44-cycle frame).
  - 0x07 gives parity bit 1.
- Mid-frame reset: assert `rst` during DATA bit 3 of 0x3C. Required: `txd` = 1 and `busy` = 0 the next edge, no extra `pop`. A following byte 0x55 transmits correctly.
- Empty FIFO: hold `fifo_empty` = 1 for 100 cycles. Required: `pop` never asserted, `txd` constant 1.

Source files
------------

// File: rtl/uart_tx.sv
// Serial transmitter: pops bytes from the upstream FIFO and sends 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       pop,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]    state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          baud_last;

    assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));

    // The byte is taken either from idle or on the last stop cycle, so frames chain without a gap.
    assign pop = !rst && !fifo_empty
                 && ((state_q == StIdle) || ((state_q == StStop) && baud_last));

    assign busy = (state_q != StIdle);

    always_comb begin
        txd = 1'b1;
        case (state_q)
            StStart:  txd = 1'b0;
            StData:   txd = shift_q[bit_q];
            StParity: txd = ^shift_q;
            default:  txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if (state_q == StIdle) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_last ? '0 : baud_q + CW'(1);
            end

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q <= fifo_dout;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
                StParity: begin
                    if (baud_last) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        if (pop) begin
                            shift_q <= fifo_dout;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a FIFO queue feeds the DUT and the expected line
// waveform is built as a per-cycle bit queue from each popped byte.
module tb_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       pop;
    logic       txd;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];   // FIFO contents
    logic       exq[$];  // expected txd, one entry per upcoming cycle

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .pop        (pop),
        .txd        (txd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        logic [10:0] bits;
        int          n;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
        n    = 11;
`else
        bits = {1'b0, 1'b1, b, 1'b0};
        n    = 10;
`endif
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < int'(CPB); k++) exq.push_back(bits[i]);
        end
    endtask

    // One clock cycle: drive FIFO at the falling edge, sample just after, update the model.
    task automatic cycle();
        logic e_pop, e_txd, e_busy;
        logic [7:0] b;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 8'($urandom) : fq[0];
        #1;
        e_busy = (exq.size() != 0);
        e_txd  = e_busy ? exq[0] : 1'b1;
        e_pop  = !rst && !fifo_empty && (exq.size() <= 1);
        check("pop", pop, e_pop);
        check("txd", txd, e_txd);
        check("busy", busy, e_busy);
        if (exq.size() != 0) void'(exq.pop_front());
        if (rst) begin
            exq.delete();
        end else if (e_pop) begin
            b = fq.pop_front();
            push_frame(b);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        @(posedge clk);
        @(negedge clk);

        // Reset held with data waiting: no pop, line idle.
        fq.push_back(8'h11);
        run(3);
        rst = 1'b0;
        run(50);

        // Single byte.
        fq.push_back(8'hA5);
        run(50);

        // Back-to-back frames.
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        run(95);

        // Parity-sensitive bytes.
        fq.push_back(8'hA5);
        fq.push_back(8'h07);
        run(95);

        // Reset during data bit 3 of 0x3C, then 0x55.
        fq.push_back(8'h3C);
        run(18);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(3);
        fq.push_back(8'h55);
        run(50);

        // Long empty stretch.
        run(100);

        // Random bytes with random arrival gaps, some arriving mid-frame.
        for (int i = 0; i < 30; i++) begin
            fq.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) fq.push_back(8'($urandom));
            run($urandom_range(1, 60));
        end
        run(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
